// File: rtl/accum_sched.sv
// ============================================================================
// accum_sched : round-robin scheduler sharing one 4-bit accumulator between
//               two requesters, with sticky carry tracking per job.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module accum_sched (
   input  logic       PHI,
   input  logic       RSTN,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic [2:0] LEN0,
   input  logic [2:0] LEN1,
   input  logic       OPV0,
   input  logic       OPV1,
   input  logic [3:0] OP0,
   input  logic [3:0] OP1,
   output logic       GNT0,
   output logic       GNT1,
   output logic       OPRDY0,
   output logic       OPRDY1,
   output logic       ACC_RST,
   output logic [3:0] ACC_A,
   output logic       ACC_CIN,
   input  logic [3:0] ACC_SOUT,
   input  logic       ACC_COUT,
   output logic       DONE,
   output logic       DONE_ID,
   output logic [3:0] RESULT,
   output logic       OVF
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CLR  = 2'd1,
      S_RUN  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [2:0] cnt_q, cnt_d;
   logic       ovf_acc_q, ovf_acc_d;
   logic [1:0] gnt_q, gnt_d;
   logic       done_q, done_d;
   logic       done_id_q, done_id_d;
   logic [3:0] result_q, result_d;
   logic       ovf_q, ovf_d;

   logic       grant;
   logic       own_opv;
   logic [3:0] own_op;
   logic [1:0] oprdy;
   logic [3:0] acc_a;

   assign own_opv = owner_q ? OPV1 : OPV0;
   assign own_op  = owner_q ? OP1  : OP0;
   // On a tie the side that did not win last time takes the grant.
   assign grant   = (REQ0 & REQ1) ? ~last_q : REQ1;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      gnt_d     = gnt_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      oprdy     = 2'b00;
      acc_a     = 4'd0;

      case (state_q)
         S_IDLE: begin
            if (REQ0 | REQ1) begin
               owner_d = grant;
               last_d  = grant;
               cnt_d   = grant ? LEN1 : LEN0;
               gnt_d   = grant ? 2'b10 : 2'b01;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            ovf_acc_d = 1'b0;
            if (cnt_q == 3'd0) begin
               gnt_d   = 2'b00;
               state_d = S_FIN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            oprdy[owner_q] = 1'b1;
            if (own_opv) begin
               acc_a     = own_op;
               ovf_acc_d = ovf_acc_q | ACC_COUT;
               cnt_d     = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  gnt_d   = 2'b00;
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            result_d  = ACC_SOUT;
            ovf_d     = ovf_acc_q;
            done_id_d = owner_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge PHI) begin
      if (!RSTN) begin
         state_q   <= S_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= 3'd0;
         ovf_acc_q <= 1'b0;
         gnt_q     <= 2'b00;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         result_q  <= 4'd0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
      end
   end

   // The accumulator is cleared together with the scheduler.
   assign ACC_RST = ~RSTN | (state_q == S_CLR);
   assign ACC_A   = acc_a;
   assign ACC_CIN = 1'b0;
   assign GNT0    = gnt_q[0];
   assign GNT1    = gnt_q[1];
   assign OPRDY0  = oprdy[0];
   assign OPRDY1  = oprdy[1];
   assign DONE    = done_q;
   assign DONE_ID = done_id_q;
   assign RESULT  = result_q;
   assign OVF     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_accum_sched.sv
// ============================================================================
// tb_accum_sched : scoreboard bench for accum_sched with an accumulator model.
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_accum_sched;

   typedef int iq_t[$];
   typedef struct { int sum; int ovf; int dc; } exp_t;

   logic       PHI = 1'b0;
   logic       RSTN = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, opv0 = 1'b0, opv1 = 1'b0;
   logic [2:0] len0 = 3'd0, len1 = 3'd0;
   logic [3:0] op0 = 4'd0, op1 = 4'd0;

   logic       GNT0, GNT1, OPRDY0, OPRDY1, ACC_RST, ACC_CIN, DONE, DONE_ID, OVF;
   logic [3:0] ACC_A, RESULT;
   logic [3:0] sout;
   logic [4:0] acc_sum;
   logic       cout;

   exp_t       q0[$], q1[$];
   int         id_log[$];
   int         errors = 0, checks = 0, cyc = 0;
   bit         chk_en = 1'b0;
   logic [1:0] gprev = 2'b00;

   accum_sched dut (
      .PHI(PHI), .RSTN(RSTN),
      .REQ0(req0), .REQ1(req1), .LEN0(len0), .LEN1(len1),
      .OPV0(opv0), .OPV1(opv1), .OP0(op0), .OP1(op1),
      .GNT0(GNT0), .GNT1(GNT1), .OPRDY0(OPRDY0), .OPRDY1(OPRDY1),
      .ACC_RST(ACC_RST), .ACC_A(ACC_A), .ACC_CIN(ACC_CIN),
      .ACC_SOUT(sout), .ACC_COUT(cout),
      .DONE(DONE), .DONE_ID(DONE_ID), .RESULT(RESULT), .OVF(OVF)
   );

   // External accumulator: registered sum, combinational carry.
   assign acc_sum = {1'b0, sout} + {1'b0, ACC_A} + {4'd0, ACC_CIN};
   assign cout    = acc_sum[4];
   always @(posedge PHI) begin
      if (ACC_RST) sout <= 4'd0;
      else         sout <= acc_sum[3:0];
   end

   always #5 PHI = ~PHI;
   always @(posedge PHI) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic iq_t mk(input int n, input int a, input int b, input int c);
      iq_t q;
      if (n > 0) q.push_back(a);
      if (n > 1) q.push_back(b);
      if (n > 2) q.push_back(c);
      return q;
   endfunction

   // Monitor: protocol rules every cycle, scoreboard pop on DONE.
   always @(negedge PHI) begin
      exp_t e;
      if (chk_en) begin
         chk("gnt_exclusive", int'(GNT0 & GNT1), 0);
         chk("oprdy0", int'(OPRDY0), int'(GNT0 & gprev[0]));
         chk("oprdy1", int'(OPRDY1), int'(GNT1 & gprev[1]));
         chk("acc_rst", int'(ACC_RST), int'(!RSTN | ((GNT0 | GNT1) & !(gprev[0] | gprev[1]))));
         chk("acc_cin", int'(ACC_CIN), 0);
         if (OPRDY0 & opv0)      chk("acc_a_op0", int'(ACC_A), int'(op0));
         else if (OPRDY1 & opv1) chk("acc_a_op1", int'(ACC_A), int'(op1));
         else                    chk("acc_a_idle", int'(ACC_A), 0);
         if (DONE) begin
            id_log.push_back(int'(DONE_ID));
            if ((DONE_ID ? q1.size() : q0.size()) == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = DONE_ID ? q1.pop_front() : q0.pop_front();
               chk("result", int'(RESULT), e.sum);
               chk("ovf", int'(OVF), e.ovf);
               chk("done_cycle", cyc, e.dc);
            end
         end
      end
      gprev = {GNT1, GNT0};
   end

   task automatic set_req(input int side, input bit r, input int n);
      if (side == 1) begin req1 = r; len1 = 3'(n); end
      else           begin req0 = r; len0 = 3'(n); end
   endtask

   task automatic drv(input int side, input bit v, input int op);
      if (side == 1) begin opv1 = v; op1 = 4'(op); end
      else           begin opv0 = v; op0 = 4'(op); end
   endtask

   // One job: the reference result is plain modular addition with a carry flag.
   task automatic job(input int side, input iq_t ops, input iq_t st);
      int   n = ops.size();
      int   s = 0, ov = 0, stalls = 0, g = 0, waited = 0, i = 0, rem = 0;
      exp_t e;
      foreach (ops[k]) begin
         s += ops[k];
         if (s > 15) begin ov = 1; s -= 16; end
      end
      @(posedge PHI); #1;
      set_req(side, 1'b1, n);
      while (1) begin
         @(posedge PHI); #1;
         if (side == 1 ? GNT1 : GNT0) break;
         waited++;
         if (waited > 300) begin
            chk("grant_timeout", 0, 1);
            set_req(side, 1'b0, 0);
            return;
         end
      end
      g = cyc;
      set_req(side, 1'b0, 0);
      waited = 0;
      if (n > 0) rem = st[0];
      while (i < n) begin
         drv(side, rem == 0, ops[i]);
         @(negedge PHI);
         if (side == 1 ? OPRDY1 : OPRDY0) begin
            if (rem == 0) begin
               i++;
               if (i < n) rem = st[i];
            end else begin
               rem--;
               stalls++;
            end
         end
         @(posedge PHI); #1;
         waited++;
         if (waited > 300) begin
            chk("operand_timeout", 0, 1);
            drv(side, 1'b0, 0);
            return;
         end
      end
      drv(side, 1'b0, 0);
      e.sum = s;
      e.ovf = ov;
      e.dc  = g + n + 2 + stalls;
      if (side == 1) q1.push_back(e);
      else           q0.push_back(e);
   endtask

   task automatic rjob(input int side);
      int  n;
      iq_t o, s;
      n = int'($urandom_range(7, 0));
      for (int k = 0; k < n; k++) begin
         o.push_back(int'($urandom_range(15, 0)));
         s.push_back(int'($urandom_range(2, 0)));
      end
      repeat ($urandom_range(3, 0)) @(posedge PHI);
      job(side, o, s);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int waited;
      RSTN = 1'b0;
      repeat (3) @(posedge PHI);
      #1 RSTN = 1'b1;
      chk_en = 1'b1;
      @(negedge PHI);
      chk("rst_gnt0", int'(GNT0), 0);
      chk("rst_gnt1", int'(GNT1), 0);
      chk("rst_oprdy0", int'(OPRDY0), 0);
      chk("rst_oprdy1", int'(OPRDY1), 0);
      chk("rst_done", int'(DONE), 0);
      chk("rst_done_id", int'(DONE_ID), 0);
      chk("rst_result", int'(RESULT), 0);
      chk("rst_ovf", int'(OVF), 0);

      // Fairness: both sides keep requesting, first tie goes to requester 0.
      id_log.delete();
      fork
         begin job(0, mk(1, 5, 0, 0), mk(1, 0, 0, 0)); job(0, mk(1, 6, 0, 0), mk(1, 1, 0, 0)); end
         begin job(1, mk(1, 7, 0, 0), mk(1, 0, 0, 0)); job(1, mk(1, 8, 0, 0), mk(1, 2, 0, 0)); end
      join
      repeat (4) @(posedge PHI);
      chk("fair_count", id_log.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < id_log.size()) chk("fair_order", id_log[k], k % 2);

      job(0, mk(3, 3, 5, 2), mk(3, 0, 0, 0));
      job(0, mk(2, 4, 7, 0), mk(2, 0, 3, 0));
      job(1, mk(2, 9, 9, 0), mk(2, 0, 0, 0));
      job(1, mk(2, 1, 1, 0), mk(2, 0, 0, 0));
      job(1, mk(2, 15, 3, 0), mk(2, 0, 1, 0));
      repeat (3) @(posedge PHI);

      // Abandon a job with a one-cycle reset while operands are streaming.
      @(posedge PHI); #1;
      req0 = 1'b1; len0 = 3'd5;
      waited = 0;
      while (!GNT0 && waited < 50) begin @(posedge PHI); #1; waited++; end
      chk("midrst_grant", int'(GNT0), 1);
      req0 = 1'b0; opv0 = 1'b1; op0 = 4'd3;
      repeat (3) @(posedge PHI);
      #1 RSTN = 1'b0;
      @(posedge PHI);
      #1 RSTN = 1'b1; opv0 = 1'b0;
      @(negedge PHI);
      chk("midrst_gnt0", int'(GNT0), 0);
      chk("midrst_oprdy0", int'(OPRDY0), 0);
      chk("midrst_done", int'(DONE), 0);
      chk("midrst_done_id", int'(DONE_ID), 0);
      chk("midrst_result", int'(RESULT), 0);
      chk("midrst_ovf", int'(OVF), 0);
      chk("midrst_sout", int'(sout), 0);
      repeat (10) @(posedge PHI);
      job(1, mk(3, 6, 6, 6), mk(3, 1, 0, 2));
      job(0, mk(0, 0, 0, 0), mk(0, 0, 0, 0));

      repeat (25) begin
         fork
            rjob(0);
            rjob(1);
         join
      end
      repeat (10) @(posedge PHI);
      chk("scoreboard_empty", q0.size() + q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/accum_sched.md
# accum_sched

Round-robin job scheduler that shares one 4-bit accumulator datapath between two requesters. Each requester submits a job of 0 to 7 four-bit operands. The scheduler clears the accumulator, streams the granted requester's operands into it with a valid/ready handshake, and tracks carry-out as sticky overflow. It then returns the 4-bit sum, the overflow flag and the owner ID. It sits between the requester logic and the accumulator's PHI/RST/A/CIN/SOUT/COUT ports.

## Interface
Parameters: none (operand width is 4, LEN width is 3).

- PHI  in  1  clock; all state changes on posedge
- RSTN  in  1  synchronous, active-low reset
- REQ0, REQ1  in  1  job request, level; sampled only in IDLE
- LEN0, LEN1  in  3  operand count for the job, 0..7; sampled with the grant
- OPV0, OPV1  in  1  operand valid
- OP0, OP1  in  4  operand data
- GNT0, GNT1  out  1  grant, registered, high from CLR through RUN
- OPRDY0, OPRDY1  out  1  operand ready, high only in RUN for the granted side
- ACC_RST  out  1  drives accumulator RST (active-high)
- ACC_A  out  4  drives accumulator A
- ACC_CIN  out  1  drives accumulator CIN; constant 0
- ACC_SOUT  in  4  accumulator registered sum
- ACC_COUT  in  1  accumulator combinational carry-out
- DONE  out  1  one-cycle completion pulse, registered
- DONE_ID  out  1  requester that owned the completed job
- RESULT  out  4  final sum, held until the next DONE
- OVF  out  1  sticky carry for the completed job, held until the next DONE

## Operation
- The FSM has four states: IDLE, CLR, RUN and FIN.
- **IDLE**
  - If any REQ is high, arbitrate round-robin on the LAST pointer:
    - only one REQ high: grant that requester;
    - both high: grant the requester other than LAST.
  - On the grant: latch the owner ID and its LEN into CNT_LEFT, set LAST to the owner, go to CLR.
- **CLR**
  - ACC_RST=1 for exactly one cycle. OVF_ACC is cleared.
  - Next state is FIN if CNT_LEFT==0, otherwise RUN.
- **RUN**
  - OPRDYx=1 for the owner only.
  - An operand is accepted when OPVx&OPRDYx.
    - ACC_A=OPx combinationally in that cycle.
    - At the edge: OVF_ACC |= ACC_COUT, CNT_LEFT decrements.
  - Stall cycles (OPVx=0): ACC_A=0, so the accumulator holds its value.
  - When the last operand is accepted (CNT_LEFT==1), go to FIN.
- **FIN**
  - GNT drops; ACC_A=0.
  - At the edge: RESULT<=ACC_SOUT, OVF<=OVF_ACC, DONE_ID<=owner, DONE<=1. Go to IDLE.
- **Outputs outside active states**
  - ACC_A=0 and ACC_CIN=0 outside accepted RUN cycles.
  - ACC_RST=1 also while RSTN=0, so the datapath clears with the scheduler.
- **Arithmetic**
  - The sum is modulo 16 (4-bit wrap).
  - OVF=1 iff any accepted operand produced a carry-out.
- **Request handling**
  - REQ/LEN changes during a job are ignored.
  - A REQ still high in IDLE (including the DONE cycle) is a new job. Requesters drop REQ after seeing GNT.
  - OPV on the non-granted side is ignored; its OPRDY stays 0.

## Timing
- **Reset values** (RSTN=0 at a posedge): state=IDLE, GNT0/1=0, OPRDY0/1=0, DONE=0, DONE_ID=0, RESULT=0, OVF=0. LAST=1, so requester 0 wins the first tie.
- **Reset mid-job:** the job is abandoned, no DONE is issued, and the accumulator is cleared.
- **Latency:** REQ sampled in IDLE at cycle c0, then:
  - CLR at c1;
  - RUN at c2..c(L+1) with no stalls;
  - FIN at c(L+2);
  - DONE=1 at c(L+3).
  - Each stall cycle adds one cycle.
- **LEN=0:** IDLE → CLR → FIN. DONE arrives at c3 with RESULT=0, OVF=0.
- **Back-to-back:** the next grant can be taken in the DONE-pulse cycle (IDLE). Its GNT rises one cycle later.
- **Fairness:** with both REQ held continuously, grants alternate 0,1,0,1.

## Test plan
- Single job: REQ0, LEN0=3, OP0 = 3, 5, 2 with no stalls → GNT0 high c1..c4, ACC_RST at c1, DONE at c6 with RESULT=10, OVF=0, DONE_ID=0.
- Overflow: REQ1, LEN1=2, OP1 = 9, 9 → RESULT=2, OVF=1, DONE_ID=1. The next job, 1+1, gives OVF=0 (sticky flag cleared per job).
- Arbitration: REQ0 and REQ1 both high from reset, each LEN=1 → grant order 0,1,0,1. DONE_ID alternates; GNT0 and GNT1 are never high together.
- Stalls: LEN0=2 with OPV0 low for 3 cycles between operands 4 and 7 → ACC_SOUT holds 4 through the stall, RESULT=11, DONE at c8.
- LEN=0: REQ0, LEN0=0 → OPRDY0 never asserted, DONE at c3, RESULT=0, OVF=0.
- Reset mid-job: RSTN low for one cycle during RUN → all outputs at reset values next cycle, ACC_RST=1, no DONE. A new REQ1 job then completes normally.
